// File: rtl/arbiter_out_fifo_pkg.sv
// Shared widths and constants for the arbiter output path, kept common with arbiter_mux
// so that word, grant and source-index widths cannot drift apart.
package arbiter_out_fifo_pkg;

    localparam int ARB_DATA_W  = 16;
    localparam int ARB_NUM_REQ = 5;
    localparam int ARB_SRC_W   = 3;
    localparam int FIFO_DEPTH  = 8;
    localparam int FIFO_AW     = 3;

    // Source index reported for a zero or multi-hot grant.
    localparam logic [ARB_SRC_W-1:0] SRC_BAD = '1;

endpackage

// File: rtl/arbiter_onehot_enc.sv
// One-hot grant to source index encoder with a validity flag; purely combinational.
// Non-one-hot grants encode to all-ones so they can never alias a real requester.
module arbiter_onehot_enc #(
    parameter int NUM_REQ = 5,
    parameter int SRC_W   = 3
) (
    input  logic [NUM_REQ-1:0] grant,
    output logic [SRC_W-1:0]   src,
    output logic               onehot_ok
);

    logic [SRC_W-1:0] idx;

    always_comb begin
        idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                idx = SRC_W'(k);
            end
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign onehot_ok = (grant != '0) && ((grant & (grant - NUM_REQ'(1))) == '0);
    assign src       = onehot_ok ? idx : '1;

endmodule

// File: rtl/arbiter_out_fifo.sv
// Output buffer behind arbiter_mux: stores word + encoded source, first-word-fall-through, 1-cycle latency.
// valid/ready out; when full a word is accepted only if the head pops the same cycle, otherwise dropped (overflow).
module arbiter_out_fifo
    import arbiter_out_fifo_pkg::*;
#(
    parameter int DATA_W  = ARB_DATA_W,
    parameter int NUM_REQ = ARB_NUM_REQ,
    parameter int SRC_W   = ARB_SRC_W,
    parameter int DEPTH   = FIFO_DEPTH,
    parameter int AW      = FIFO_AW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [NUM_REQ-1:0] in_grant,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [SRC_W-1:0]   out_src,
    output logic [AW:0]        level,
    output logic               full,
    output logic               empty,
    output logic               overflow,
    output logic               grant_err
);

    localparam int EW = DATA_W + SRC_W;

    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level_nxt;
    logic [SRC_W-1:0] enc_src;
    logic             onehot_ok;
    logic             push;
    logic             pop;

    arbiter_onehot_enc #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_enc (
        .grant     (in_grant),
        .src       (enc_src),
        .onehot_ok (onehot_ok)
    );

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign push      = in_valid && (!full || pop);

    always_comb begin
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + (AW+1)'(1);
            2'b01:   level_nxt = level - (AW+1)'(1);
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            grant_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_nxt;
            full  <= (level_nxt == (AW+1)'(DEPTH));
            empty <= (level_nxt == '0);
            if (in_valid && full && !pop) begin
                overflow <= 1'b1;
            end
            if (in_valid && !onehot_ok) begin
                grant_err <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; the head is masked while empty instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_data, enc_src};
        end
    end

    assign out_data = empty ? '0 : mem[rd_ptr][EW-1:SRC_W];
    assign out_src  = empty ? '0 : mem[rd_ptr][SRC_W-1:0];

endmodule

// File: tb/tb_arbiter_out_fifo.sv
// Scoreboard bench for arbiter_out_fifo: expected words queued at drive time, compared at the head.
module tb_arbiter_out_fifo;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic [4:0]  in_grant;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_src;
    logic [3:0]  level;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        grant_err;

    typedef struct packed {
        logic [15:0] d;
        logic [2:0]  s;
    } exp_t;

    exp_t sbq[$];
    int   mlevel;
    bit   movf;
    bit   mgerr;
    int   n_chk;
    int   n_fail;

    arbiter_out_fifo dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_grant  (in_grant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .grant_err (grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] model_src(input logic [4:0] g);
        int cnt;
        int idx;
        cnt = 0;
        idx = 0;
        for (int k = 0; k < 5; k++) begin
            if (g[k]) begin
                cnt++;
                idx = k;
            end
        end
        return (cnt == 1) ? 3'(idx) : 3'b111;
    endfunction

    // Drives one cycle of stimulus, updates the reference model and scoreboard.
    task automatic drive(input logic vld, input logic [15:0] d, input logic [4:0] g, input logic rdy);
        bit do_pop;
        bit do_push;
        in_valid  = vld;
        in_data   = d;
        in_grant  = g;
        out_ready = rdy;
        do_pop  = rdy && (mlevel > 0);
        do_push = vld && ((mlevel < 8) || do_pop);
        if (do_pop) void'(sbq.pop_front());
        if (do_push) sbq.push_back({d, model_src(g)});
        if (vld && !do_push) movf = 1'b1;
        if (vld && model_src(g) == 3'b111) mgerr = 1'b1;
        mlevel = mlevel + int'(do_push) - int'(do_pop);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        sbq.delete();
        mlevel = 0;
        movf   = 1'b0;
        mgerr  = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (out_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: valid=%b empty=%b full=%b want 0/1/0", out_valid, empty, full); end
        n_chk++; if (level !== 4'd0 || overflow !== 1'b0 || grant_err !== 1'b0) begin n_fail++; $display("FAIL reset_status: level=%0d ovf=%b gerr=%b want 0/0/0", level, overflow, grant_err); end
        n_chk++; if (out_data !== 16'h0 || out_src !== 3'd0) begin n_fail++; $display("FAIL reset_head: data=%h src=%0d want 0000/0", out_data, out_src); end
        reset = 1'b1;
    endtask

    task automatic test_single();
        drive(1'b1, 16'h000C, 5'b00100, 1'b0);
        n_chk++; if ({out_valid, out_data, out_src, level} !== {1'b1, 16'h000C, 3'd2, 4'd1}) begin n_fail++; $display("FAIL single_head: valid=%b data=%h src=%0d level=%0d want 1/000c/2/1", out_valid, out_data, out_src, level); end
        repeat (3) drive(1'b0, 16'hFFFF, 5'b11111, 1'b0);
        n_chk++; if ({out_valid, out_data, out_src, level} !== {1'b1, 16'h000C, 3'd2, 4'd1}) begin n_fail++; $display("FAIL single_hold: valid=%b data=%h src=%0d level=%0d want 1/000c/2/1", out_valid, out_data, out_src, level); end
        n_chk++; if (grant_err !== 1'b0) begin n_fail++; $display("FAIL single_idle_grant: gerr=%b want 0", grant_err); end
        drive(1'b0, 16'h0, 5'b0, 1'b1);
        n_chk++; if (empty !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop: empty=%b valid=%b want 1/0", empty, out_valid); end
    endtask

    task automatic test_order();
        drive(1'b1, 16'h000D, 5'b01000, 1'b0);
        drive(1'b1, 16'h000C, 5'b00100, 1'b0);
        n_chk++; if (level !== 4'(mlevel)) begin n_fail++; $display("FAIL order_level: got %0d want %0d", level, mlevel); end
        for (int i = 0; i < 2; i++) begin
            n_chk++; if ({out_valid, out_data, out_src} !== {1'b1, sbq[0]}) begin n_fail++; $display("FAIL order_pop%0d: got %b/%h/%0d want 1/%h/%0d", i, out_valid, out_data, out_src, sbq[0].d, sbq[0].s); end
            drive(1'b0, 16'h0, 5'b0, 1'b1);
        end
        n_chk++; if (empty !== 1'b1 || level !== 4'd0) begin n_fail++; $display("FAIL order_empty: empty=%b level=%0d want 1/0", empty, level); end
    endtask

    task automatic test_full_pushpop();
        for (int i = 0; i < 8; i++) drive(1'b1, 16'h0200 + 16'(i), 5'(1 << (i % 5)), 1'b0);
        n_chk++; if (full !== 1'b1 || level !== 4'd8) begin n_fail++; $display("FAIL fpp_full: full=%b level=%0d want 1/8", full, level); end
        n_chk++; if ({out_data, out_src} !== sbq[0]) begin n_fail++; $display("FAIL fpp_head: got %h/%0d want %h/%0d", out_data, out_src, sbq[0].d, sbq[0].s); end
        drive(1'b1, 16'h0AAA, 5'b00001, 1'b1);
        n_chk++; if (level !== 4'd8 || full !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_same: level=%0d full=%b ovf=%b want 8/1/0", level, full, overflow); end
        for (int i = 0; i < 8; i++) begin
            n_chk++; if ({out_valid, out_data, out_src} !== {1'b1, sbq[0]}) begin n_fail++; $display("FAIL fpp_drain%0d: got %b/%h/%0d want 1/%h/%0d", i, out_valid, out_data, out_src, sbq[0].d, sbq[0].s); end
            if (i == 7) begin
                n_chk++; if (out_data !== 16'h0AAA || out_src !== 3'd0) begin n_fail++; $display("FAIL fpp_new_last: got %h/%0d want 0aaa/0", out_data, out_src); end
            end
            drive(1'b0, 16'h0, 5'b0, 1'b1);
        end
        n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fpp_empty: empty=%b want 1", empty); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 16'h0100 + 16'(i), 5'(1 << (i % 5)), 1'b0);
            if (i == 7) begin
                n_chk++; if (full !== 1'b1 || level !== 4'd8 || overflow !== 1'b0) begin n_fail++; $display("FAIL fill_full: full=%b level=%0d ovf=%b want 1/8/0", full, level, overflow); end
            end
        end
        n_chk++; if (level !== 4'd8 || overflow !== movf || !movf) begin n_fail++; $display("FAIL fill_ovf: level=%0d ovf=%b want 8/1", level, overflow); end
        for (int i = 0; i < 8; i++) begin
            n_chk++; if ({out_valid, out_data, out_src} !== {1'b1, sbq[0]}) begin n_fail++; $display("FAIL fill_drain%0d: got %b/%h/%0d want 1/%h/%0d", i, out_valid, out_data, out_src, sbq[0].d, sbq[0].s); end
            drive(1'b0, 16'h0, 5'b0, 1'b1);
        end
        n_chk++; if (empty !== 1'b1 || overflow !== 1'b1) begin n_fail++; $display("FAIL fill_after: empty=%b ovf=%b want 1/1", empty, overflow); end
        drive(1'b0, 16'h0, 5'b0, 1'b1);
        n_chk++; if (level !== 4'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_noop_pop: level=%0d valid=%b want 0/0", level, out_valid); end
    endtask

    task automatic test_bad_grant();
        drive(1'b0, 16'h1234, 5'b00000, 1'b0);
        n_chk++; if (level !== 4'd0 || grant_err !== 1'b0) begin n_fail++; $display("FAIL bad_idle: level=%0d gerr=%b want 0/0", level, grant_err); end
        drive(1'b1, 16'h0BAD, 5'b01100, 1'b0);
        n_chk++; if ({out_valid, out_data, out_src, grant_err} !== {1'b1, 16'h0BAD, 3'b111, 1'b1}) begin n_fail++; $display("FAIL bad_multi: got %b/%h/%0d gerr=%b want 1/0bad/7/1", out_valid, out_data, out_src, grant_err); end
        drive(1'b1, 16'h0EEE, 5'b00000, 1'b0);
        drive(1'b1, 16'h0F0F, 5'b10000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_chk++; if ({out_valid, out_data, out_src} !== {1'b1, sbq[0]}) begin n_fail++; $display("FAIL bad_drain%0d: got %b/%h/%0d want 1/%h/%0d", i, out_valid, out_data, out_src, sbq[0].d, sbq[0].s); end
            drive(1'b0, 16'h0, 5'b0, 1'b1);
        end
        n_chk++; if (grant_err !== mgerr || empty !== 1'b1) begin n_fail++; $display("FAIL bad_sticky: gerr=%b empty=%b want %b/1", grant_err, empty, mgerr); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) drive(1'b1, 16'h0300 + 16'(i), 5'b00010, 1'b0);
        drive(1'b1, 16'h0400, 5'b00011, 1'b0);
        #2 reset = 1'b0;
        #1;
        n_chk++; if ({out_valid, empty, full, level} !== {1'b0, 1'b1, 1'b0, 4'd0}) begin n_fail++; $display("FAIL rmid_flags: valid=%b empty=%b full=%b level=%0d want 0/1/0/0", out_valid, empty, full, level); end
        n_chk++; if ({grant_err, overflow, out_data, out_src} !== 21'd0) begin n_fail++; $display("FAIL rmid_status: gerr=%b ovf=%b data=%h src=%0d want all 0", grant_err, overflow, out_data, out_src); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        sbq.delete();
        mlevel = 0;
        movf   = 1'b0;
        mgerr  = 1'b0;
        drive(1'b1, 16'h0555, 5'b00001, 1'b0);
        n_chk++; if ({out_valid, out_data, out_src, level} !== {1'b1, 16'h0555, 3'd0, 4'd1}) begin n_fail++; $display("FAIL rmid_after: got %b/%h/%0d level=%0d want 1/0555/0/1", out_valid, out_data, out_src, level); end
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_grant  = '0;
        out_ready = 1'b0;
        mlevel    = 0;
        movf      = 1'b0;
        mgerr     = 1'b0;
        n_chk     = 0;
        n_fail    = 0;
        test_reset();
        test_single();
        test_order();
        test_full_pushpop();
        test_fill_overflow();
        do_reset();
        test_bad_grant();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
